// File: rtl/grf_scoreboard.sv
// ============================================================================
// Module   : grf_scoreboard
// Brief    : Parametrised 2R/2W register file with write-to-read bypass and a
//            per-register pending-write scoreboard for the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic [31:0]       wa_pc,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [31:0]       wb_pc,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_full
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = CNT_W + 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt [DEPTH];

  logic w_wa_eff;
  logic w_wb_eff;
  logic [1:0] w_dec1;
  logic [1:0] w_dec2;

  assign w_wa_eff = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
  assign w_wb_eff = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

  // Storage: B first so A wins on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wb_eff) r_mem[wb_addr] <= wb_data;
      if (w_wa_eff) r_mem[wa_addr] <= wa_data;
    end
  end

  // Read ports with bypass; bypass is suppressed while in reset.
  always_comb begin
    rd_data1 = r_mem[rd_addr1];
    if (!reset) begin
      if (w_wa_eff && (wa_addr == rd_addr1))      rd_data1 = wa_data;
      else if (w_wb_eff && (wb_addr == rd_addr1)) rd_data1 = wb_data;
    end
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = r_mem[rd_addr2];
    if (!reset) begin
      if (w_wa_eff && (wa_addr == rd_addr2))      rd_data2 = wa_data;
      else if (w_wb_eff && (wb_addr == rd_addr2)) rd_data2 = wb_data;
    end
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_data2 = '0;
  end

  // Busy only if a pending write survives this cycle's writebacks.
  assign w_dec1 = {1'b0, (w_wa_eff && (wa_addr == rd_addr1))}
                + {1'b0, (w_wb_eff && (wb_addr == rd_addr1))};
  assign w_dec2 = {1'b0, (w_wa_eff && (wa_addr == rd_addr2))}
                + {1'b0, (w_wb_eff && (wb_addr == rd_addr2))};

  assign rd_busy1 = {1'b0, r_cnt[rd_addr1]} > CW'(w_dec1);
  assign rd_busy2 = {1'b0, r_cnt[rd_addr2]} > CW'(w_dec2);
  assign rsv_full = (r_cnt[rsv_addr] == C_CNT_MAX);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
    localparam logic [ADDR_W-1:0] C_IDX  = ADDR_W'(g);
    localparam logic              C_HARD = (ZERO_REG != 0) && (g == 0);

    logic          w_inc;
    logic [1:0]    w_dec;
    logic [CW-1:0] w_sum;
    logic [CW-1:0] w_next;

    assign w_inc = rsv_en && (rsv_addr == C_IDX) && (r_cnt[g] != C_CNT_MAX) && !C_HARD;
    assign w_dec = {1'b0, (w_wa_eff && (wa_addr == C_IDX))}
                 + {1'b0, (w_wb_eff && (wb_addr == C_IDX))};
    assign w_sum = {1'b0, r_cnt[g]} + CW'(w_inc);
    // Clamp at zero so unreserved writes cannot underflow the counter.
    assign w_next = (w_sum > CW'(w_dec)) ? (w_sum - CW'(w_dec)) : '0;

    always_ff @(posedge clk) begin
      if (reset) r_cnt[g] <= '0;
      else       r_cnt[g] <= w_next[CNT_W-1:0];
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      if (w_wa_eff)
        $display("%d@%h: $%d <= %h", $time, wa_pc, wa_addr, wa_data);
      if (w_wb_eff && !(w_wa_eff && (wa_addr == wb_addr)))
        $display("%d@%h: $%d <= %h", $time, wb_pc, wb_addr, wb_data);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
// ============================================================================
// Module   : tb_grf_scoreboard
// Brief    : Directed self-checking bench for grf_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2, wa_addr, wb_addr, rsv_addr;
  logic [31:0] rd_data1, rd_data2, wa_data, wb_data, wa_pc, wb_pc;
  logic        rd_busy1, rd_busy2, wa_en, wb_en, rsv_en, rsv_full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grf_scoreboard dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_pc(wa_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_full(rsv_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; rsv_en = 0;
  endtask

  initial begin
    reset = 1; idle();
    rd_addr1 = 0; rd_addr2 = 0; rsv_addr = 0;
    wa_addr = 0; wb_addr = 0; wa_data = 0; wb_data = 0; wa_pc = 0; wb_pc = 0;
    repeat (2) tick();
    reset = 0;
    #1;

    // Reset state over every address
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a); rsv_addr = 5'(a);
      #1;
      chk("rst_data1", rd_data1, 32'h0);
      chk("rst_data2", rd_data2, 32'h0);
      chk("rst_busy",  {30'b0, rd_busy1, rd_busy2}, 32'h0);
      chk("rst_full",  {31'b0, rsv_full}, 32'h0);
    end

    // Port A write with same-cycle bypass, then storage read
    tick();
    wa_en = 1; wa_addr = 5; wa_data = 32'h12345678; wa_pc = 32'h0040_0010;
    rd_addr1 = 5; rd_addr2 = 6;
    #1;
    chk("wa_bypass", rd_data1, 32'h12345678);
    chk("wa_other",  rd_data2, 32'h0);
    tick(); idle(); #1;
    chk("wa_stored", rd_data1, 32'h12345678);

    // Port B bypass on a different address while A writes elsewhere
    wa_en = 1; wa_addr = 7; wa_data = 32'h77;
    wb_en = 1; wb_addr = 6; wb_data = 32'h66; wb_pc = 32'h0040_0020;
    rd_addr1 = 7; rd_addr2 = 6;
    #1;
    chk("ab_bypA", rd_data1, 32'h77);
    chk("ab_bypB", rd_data2, 32'h66);
    tick(); idle(); #1;
    chk("ab_stB", rd_data2, 32'h66);

    // $0 hardwired: writes and reservations ignored
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF;
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    rsv_en = 1; rsv_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
    #1;
    chk("z_byp", rd_data1, 32'h0);
    repeat (4) tick();
    idle(); #1;
    chk("z_data", rd_data2, 32'h0);
    chk("z_busy", {31'b0, rd_busy1}, 32'h0);
    chk("z_full", {31'b0, rsv_full}, 32'h0);

    // Reserve $8 to the maximum of 3
    rsv_en = 1; rsv_addr = 8; rd_addr1 = 8;
    repeat (3) tick();
    rsv_en = 0; #1;
    chk("r8_full", {31'b0, rsv_full}, 32'h1);
    chk("r8_busy", {31'b0, rd_busy1}, 32'h1);
    rsv_en = 1; #1;
    chk("r8_full4", {31'b0, rsv_full}, 32'h1);
    tick(); rsv_en = 0;
    // First wb write: 3 -> 2, still busy while bypassing
    wb_en = 1; wb_addr = 8; wb_data = 32'h81;
    #1;
    chk("r8_wb1_byp",  rd_data1, 32'h81);
    chk("r8_wb1_busy", {31'b0, rd_busy1}, 32'h1);
    tick();
    chk("r8_cnt2_full", {31'b0, rsv_full}, 32'h0);
    wb_data = 32'h82;
    tick(); idle(); #1;
    chk("r8_cnt1_busy", {31'b0, rd_busy1}, 32'h1);
    chk("r8_cnt1_data", rd_data1, 32'h82);
    // Final write: bypass value is not busy
    wa_en = 1; wa_addr = 8; wa_data = 32'h83;
    #1;
    chk("r8_last_busy", {31'b0, rd_busy1}, 32'h0);
    chk("r8_last_byp",  rd_data1, 32'h83);
    tick(); idle(); #1;
    chk("r8_done_busy", {31'b0, rd_busy1}, 32'h0);

    // $9: count 2, A/B collision -> A wins and count drops to 0
    rsv_en = 1; rsv_addr = 9; rd_addr1 = 9;
    repeat (2) tick();
    rsv_en = 0;
    wa_en = 1; wa_addr = 9; wa_data = 32'hA;
    wb_en = 1; wb_addr = 9; wb_data = 32'hB;
    #1;
    chk("c9_byp",  rd_data1, 32'hA);
    chk("c9_busy", {31'b0, rd_busy1}, 32'h0);
    tick(); idle(); #1;
    chk("c9_store", rd_data1, 32'hA);
    chk("c9_cnt0",  {31'b0, rd_busy1}, 32'h0);
    // Unreserved write must not underflow
    wa_en = 1; wa_data = 32'hC;
    tick(); idle();
    rsv_en = 1;
    tick(); rsv_en = 0; #1;
    chk("c9_nouf_busy", {31'b0, rd_busy1}, 32'h1);
    chk("c9_nouf_full", {31'b0, rsv_full}, 32'h0);

    // $3: reserve+write same cycle from count 1 keeps count 1
    rsv_en = 1; rsv_addr = 3; rd_addr1 = 3; rd_addr2 = 5;
    tick();
    wa_en = 1; wa_addr = 3; wa_data = 32'h33;
    tick(); idle(); #1;
    chk("r3_busy", {31'b0, rd_busy1}, 32'h1);
    chk("r3_data", rd_data1, 32'h33);
    rsv_en = 1;
    tick(); rsv_en = 0;
    tick(); #1;
    chk("r3_cnt2_busy", {31'b0, rd_busy1}, 32'h1);
    // Reset with concurrent write and reservation
    reset = 1; wa_en = 1; wa_addr = 3; wa_data = 32'h44; rsv_en = 1;
    #1;
    chk("rst_nobyp", rd_data1, 32'h33);
    tick(); reset = 0; idle(); #1;
    chk("rst3_data", rd_data1, 32'h0);
    chk("rst3_busy", {31'b0, rd_busy1}, 32'h0);
    chk("rst5_data", rd_data2, 32'h0);
    chk("rst_full2", {31'b0, rsv_full}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
